fp_div_iter: RTL and testbench

Iterative single-precision floating-point divider that produces the unrounded sign/exponent/significand/guard-round-sticky bundle consumed directly by the rounding stage (`fp_rnd`). It accepts two IEEE-754 binary32 operands and a rounding mode with a start pulse. It runs a radix-2 restoring division over a fixed number of cycles and presents one `fp_rnd_in_type` record with a one-cycle ready strobe. Special operands bypass the iteration with 1-cycle latency.

---
 rtl/fp_div_iter_pkg.sv | 68 ++++++
 rtl/fp_div_iter_if.sv | 23 ++
 rtl/fp_div_iter_lzc.sv | 17 +
 rtl/fp_div_iter.sv | 227 ++++++++++++++++++++++
 tb/tb_fp_div_iter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp_div_iter_pkg.sv
// Shared types for the iterative binary32 divider: the record handed to the
// rounding stage, request/response bundles, FSM states and operand classes.
package fp_div_iter_pkg;

   // Quotient bits produced by the restoring loop (one per cycle).
   localparam int DIV_CYCLES = 27;

   // Unrounded result record consumed by the rounder.
   typedef struct packed {
      logic        sig;
      logic [10:0] expo;
      logic [24:0] mant;
      logic [1:0]  rema;
      logic [1:0]  fmt;
      logic [2:0]  rm;
      logic [2:0]  grs;
      logic        snan;
      logic        qnan;
      logic        dbz;
      logic        inf;
      logic        zero;
   } fp_rnd_in_type;

   typedef struct packed {
      logic        start;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  rm;
   } fp_div_in_type;

   typedef struct packed {
      logic ready;
      logic busy;
   } fp_div_out_type;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIV,
      ST_NORM,
      ST_DONE
   } fp_div_state_t;

   // Operand class flags; at most one is set, none for a normal number.
   typedef struct packed {
      logic zero;
      logic sub;
      logic inf;
      logic snan;
      logic qnan;
   } fp_class_t;

   function automatic fp_class_t fp_classify(input logic [31:0] x);
      fp_class_t c;
      logic      e_max;
      logic      e_zero;
      logic      f_zero;
      e_max  = &x[30:23];
      e_zero = ~|x[30:23];
      f_zero = ~|x[22:0];
      c.zero = e_zero & f_zero;
      c.sub  = e_zero & ~f_zero;
      c.inf  = e_max & f_zero;
      c.snan = e_max & ~f_zero & ~x[22];
      c.qnan = e_max & x[22];
      return c;
   endfunction

endpackage

// File: rtl/fp_div_iter_if.sv
// Request/response bundle between a divider client and fp_div_iter.
interface fp_div_iter_if;
   import fp_div_iter_pkg::*;

   logic          fp_div_start;
   logic [31:0]   fp_div_a;
   logic [31:0]   fp_div_b;
   logic [2:0]    fp_div_rm;
   logic          fp_div_busy;
   logic          fp_div_ready;
   fp_rnd_in_type fp_rnd_o;

   modport master (
      output fp_div_start, fp_div_a, fp_div_b, fp_div_rm,
      input  fp_div_busy, fp_div_ready, fp_rnd_o
   );

   modport slave (
      input  fp_div_start, fp_div_a, fp_div_b, fp_div_rm,
      output fp_div_busy, fp_div_ready, fp_rnd_o
   );

endinterface

// File: rtl/fp_div_iter_lzc.sv
// Leading-zero counter for a 23-bit binary32 fraction; returns 23 for zero.
module fp_div_iter_lzc (
   input  logic [22:0] i_data,
   output logic [4:0]  o_count
);

   // Scan upward so the highest set bit writes last and wins.
   always_comb begin
      o_count = 5'd23;
      for (int i = 0; i < 23; i++) begin
         if (i_data[i]) begin
            o_count = 5'(22 - i);
         end
      end
   end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative binary32 divider: radix-2 restoring loop producing the unrounded
// sign/exponent/significand/GRS record for the rounding stage. Special
// operands bypass the loop and complete one cycle after the start strobe.
module fp_div_iter
   import fp_div_iter_pkg::*;
(
   input logic          clock,
   input logic          reset,
   fp_div_iter_if.slave bus
);

   fp_div_in_type  w_req;
   fp_div_state_t  r_state;
   fp_div_out_type r_out;
   fp_rnd_in_type  r_rnd;
   logic [4:0]     r_cnt;
   logic           r_sig;
   logic [2:0]     r_rm;
   logic [10:0]    r_exp;
   logic [23:0]    r_mb;
   logic [25:0]    r_rem;
   logic [26:0]    r_quo;

   assign w_req = '{start: bus.fp_div_start, a: bus.fp_div_a,
                    b: bus.fp_div_b, rm: bus.fp_div_rm};

   assign bus.fp_div_busy  = r_out.busy;
   assign bus.fp_div_ready = r_out.ready;
   assign bus.fp_rnd_o     = r_rnd;

   // ---------------------------------------------------------------- decode
   logic [4:0]  w_lz_a;
   logic [4:0]  w_lz_b;
   fp_class_t   w_cls_a;
   fp_class_t   w_cls_b;
   logic [23:0] w_ma;
   logic [23:0] w_mb;
   logic [10:0] w_ea;
   logic [10:0] w_eb;
   logic [10:0] w_e_start;

   fp_div_iter_lzc u_lzc_a (.i_data(w_req.a[22:0]), .o_count(w_lz_a));
   fp_div_iter_lzc u_lzc_b (.i_data(w_req.b[22:0]), .o_count(w_lz_b));

   // Unpack operands into 24-bit significands and 11-bit two's-complement
   // exponents. A subnormal fraction is shifted until its top set bit sits
   // in the hidden position; its value frac*2^-149 equals m*2^(e'-150) with
   // m = frac<<(lz+1), hence e' = -lz.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the block leaves it unassigned and no latch is inferred.
      w_cls_a = fp_classify(w_req.a);
      w_cls_b = fp_classify(w_req.b);
      w_ma    = {1'b1, w_req.a[22:0]};
      w_mb    = {1'b1, w_req.b[22:0]};
      w_ea    = {3'b000, w_req.a[30:23]};
      w_eb    = {3'b000, w_req.b[30:23]};
      if (w_cls_a.sub) begin
         w_ma = {1'b0, w_req.a[22:0]} << (w_lz_a + 5'd1);
         w_ea = 11'd0 - {6'd0, w_lz_a};
      end
      if (w_cls_b.sub) begin
         w_mb = {1'b0, w_req.b[22:0]} << (w_lz_b + 5'd1);
         w_eb = 11'd0 - {6'd0, w_lz_b};
      end
      w_e_start = w_ea - w_eb + 11'd127;
   end

   // ---------------------------------------------------------- special cases
   logic          w_a_nan;
   logic          w_b_nan;
   logic          w_a_fin;
   logic          w_is_snan;
   logic          w_is_qnan;
   logic          w_is_dbz;
   logic          w_is_inf;
   logic          w_is_zero;
   logic          w_special;
   fp_rnd_in_type w_spec_rnd;

   // Priority-encode the invalid / NaN / divide-by-zero / inf / zero outcomes.
   always_comb begin
      w_a_nan   = w_cls_a.snan | w_cls_a.qnan;
      w_b_nan   = w_cls_b.snan | w_cls_b.qnan;
      w_a_fin   = ~w_cls_a.inf & ~w_a_nan;
      w_is_snan = w_cls_a.snan | w_cls_b.snan |
                  (w_cls_a.zero & w_cls_b.zero) | (w_cls_a.inf & w_cls_b.inf);
      w_is_qnan = ~w_is_snan & (w_a_nan | w_b_nan);
      w_is_dbz  = ~w_is_snan & ~w_is_qnan & w_a_fin & ~w_cls_a.zero & w_cls_b.zero;
      w_is_inf  = ~w_is_snan & ~w_is_qnan & w_cls_a.inf;
      w_is_zero = ~w_is_snan & ~w_is_qnan &
                  (w_cls_a.zero | (w_a_fin & w_cls_b.inf));
      w_special = w_is_snan | w_is_qnan | w_is_dbz | w_is_inf | w_is_zero;

      w_spec_rnd      = '0;
      w_spec_rnd.sig  = w_req.a[31] ^ w_req.b[31];
      w_spec_rnd.rm   = w_req.rm;
      w_spec_rnd.snan = w_is_snan;
      w_spec_rnd.qnan = w_is_qnan;
      w_spec_rnd.dbz  = w_is_dbz;
      w_spec_rnd.inf  = w_is_inf;
      w_spec_rnd.zero = w_is_zero;
   end

   // ------------------------------------------------------------ divide step
   logic [26:0] w_trial;
   logic        w_q_bit;
   logic [25:0] w_rem_kept;

   // One restoring step: keep R-mb when it does not borrow. Comparing before
   // the shift (rather than after) aligns the first quotient bit with 2^0 of
   // ma/mb, giving Q = floor(ma*2^26/mb) after 27 steps.
   always_comb begin
      w_trial    = {1'b0, r_rem} - {3'b000, r_mb};
      w_q_bit    = ~w_trial[26];
      w_rem_kept = w_q_bit ? w_trial[25:0] : r_rem;
   end

   // ---------------------------------------------------------- normalisation
   logic          w_q_top;
   logic [23:0]   w_sig24;
   logic [2:0]    w_grs;
   logic [10:0]   w_e_norm;
   logic          w_tiny;
   logic [10:0]   w_sh_full;
   logic [4:0]    w_shamt;
   logic [26:0]   w_frame;
   logic [26:0]   w_frame_sh;
   logic [26:0]   w_mask;
   logic          w_lost;
   fp_rnd_in_type w_norm_rnd;

   // Pick the 24-bit significand from Q, then denormalise tiny results by
   // shifting right and folding every lost bit into the sticky position.
   always_comb begin
      w_q_top    = r_quo[26];
      w_sig24    = w_q_top ? r_quo[26:3] : r_quo[25:2];
      w_grs      = w_q_top ? r_quo[2:0]  : {r_quo[1:0], 1'b0};
      w_e_norm   = w_q_top ? r_exp : r_exp - 11'd1;
      w_tiny     = $signed(w_e_norm) < 11'sd1;
      w_sh_full  = 11'd1 - w_e_norm;
      w_shamt    = (w_sh_full > 11'd26) ? 5'd26 : w_sh_full[4:0];
      w_frame    = {w_sig24, w_grs};
      w_frame_sh = w_frame >> w_shamt;
      w_mask     = (27'd1 << w_shamt) - 27'd1;
      w_lost     = |(w_frame & w_mask);

      w_norm_rnd      = '0;
      w_norm_rnd.sig  = r_sig;
      w_norm_rnd.rm   = r_rm;
      w_norm_rnd.rema = {1'b0, |r_rem};
      if (w_tiny) begin
         w_norm_rnd.expo = 11'd0;
         w_norm_rnd.mant = {1'b0, w_frame_sh[26:3]};
         w_norm_rnd.grs  = {w_frame_sh[2:1], w_frame_sh[0] | w_lost};
      end else begin
         w_norm_rnd.expo = w_e_norm;
         w_norm_rnd.mant = {1'b0, w_sig24};
         w_norm_rnd.grs  = w_grs;
      end
   end

   // ------------------------------------------------------------------- FSM
   // Control FSM with the iteration datapath and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: all state uses non-blocking assignment so every register in
      // this block updates from the values present before the edge.
      if (!reset) begin
         r_state <= ST_IDLE;
         r_out   <= '0;
         r_rnd   <= '0;
         r_cnt   <= '0;
         r_sig   <= 1'b0;
         r_rm    <= '0;
         r_exp   <= '0;
         r_mb    <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_out.ready <= 1'b0;
               if (w_req.start) begin
                  r_out.busy <= 1'b1;
                  r_sig      <= w_req.a[31] ^ w_req.b[31];
                  r_rm       <= w_req.rm;
                  if (w_special) begin
                     r_rnd       <= w_spec_rnd;
                     r_out.ready <= 1'b1;
                     r_state     <= ST_DONE;
                  end else begin
                     r_exp   <= w_e_start;
                     r_rem   <= {2'b00, w_ma};
                     r_mb    <= w_mb;
                     r_quo   <= '0;
                     r_cnt   <= 5'(DIV_CYCLES - 1);
                     r_state <= ST_DIV;
                  end
               end
            end
            ST_DIV: begin
               r_rem <= w_rem_kept << 1;
               r_quo <= {r_quo[25:0], w_q_bit};
               if (r_cnt == 5'd0) begin
                  r_state <= ST_NORM;
               end else begin
                  r_cnt <= r_cnt - 5'd1;
               end
            end
            ST_NORM: begin
               r_rnd       <= w_norm_rnd;
               r_out.ready <= 1'b1;
               r_state     <= ST_DONE;
            end
            ST_DONE: begin
               r_out.ready <= 1'b0;
               r_out.busy  <= 1'b0;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: vector table for results and latency,
// plus hand-written handshake and mid-operation reset sequences.
module tb_fp_div_iter;
   import fp_div_iter_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   fp_div_iter_if bus ();

   fp_div_iter dut (
      .clock(clk),
      .reset(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]   a;
      logic [31:0]   b;
      logic [2:0]    rm;
      int            lat;
      fp_rnd_in_type exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic fp_rnd_in_type rnd_num(input logic sig, input logic [10:0] expo,
                                             input logic [24:0] mant, input logic [2:0] grs,
                                             input logic [1:0] rema, input logic [2:0] rm);
      fp_rnd_in_type r;
      r      = '0;
      r.sig  = sig;
      r.expo = expo;
      r.mant = mant;
      r.grs  = grs;
      r.rema = rema;
      r.rm   = rm;
      return r;
   endfunction

   function automatic fp_rnd_in_type rnd_flag(input logic sig, input logic [2:0] rm,
                                              input logic [4:0] flags);
      fp_rnd_in_type r;
      r      = '0;
      r.sig  = sig;
      r.rm   = rm;
      {r.snan, r.qnan, r.dbz, r.inf, r.zero} = flags;
      return r;
   endfunction

   task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                      input int lat, input fp_rnd_in_type e);
      vec_t v;
      v.a   = a;
      v.b   = b;
      v.rm  = rm;
      v.lat = lat;
      v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
      @(negedge clk);
      bus.fp_div_start = 1'b1;
      bus.fp_div_a     = a;
      bus.fp_div_b     = b;
      bus.fp_div_rm    = rm;
      @(posedge clk);
      #1;
      bus.fp_div_start = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   cyc;
      logic busy_ok;
      drive_start(v.a, v.b, v.rm);
      cyc     = 1;
      busy_ok = 1'b1;
      while (!bus.fp_div_ready && cyc < 40) begin
         if (bus.fp_div_busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         cyc++;
      end
      check($sformatf("vec%0d latency", idx), 64'(cyc), 64'(v.lat));
      check($sformatf("vec%0d busy during op", idx), 64'({bus.fp_div_busy, busy_ok}), 64'(2'b11));
      check($sformatf("vec%0d result", idx), 64'(bus.fp_rnd_o), 64'(v.exp));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d ready/busy after", idx),
            64'({bus.fp_div_ready, bus.fp_div_busy}), 64'(2'b00));
      check($sformatf("vec%0d result held", idx), 64'(bus.fp_rnd_o), 64'(v.exp));
   endtask

   initial begin
      int            n_ready;
      int            first_ready;
      logic          busy_ok;
      fp_rnd_in_type exp_62;
      fp_rnd_in_type exp_13;

      rst_n            = 1'b0;
      bus.fp_div_start = 1'b0;
      bus.fp_div_a     = '0;
      bus.fp_div_b     = '0;
      bus.fp_div_rm    = '0;

      exp_62 = rnd_num(1'b0, 11'd128, 25'h0C00000, 3'b000, 2'b00, 3'd0);
      exp_13 = rnd_num(1'b0, 11'd125, 25'h0AAAAAA, 3'b100, 2'b01, 3'd0);

      // Finite operands: 29-cycle latency.
      add(32'h40C00000, 32'h40000000, 3'd0, 29, exp_62);                                    // 6/2
      add(32'h3F800000, 32'h40400000, 3'd0, 29, exp_13);                                    // 1/3
      add(32'hC0C00000, 32'h40000000, 3'd3, 29, rnd_num(1, 128, 25'h0C00000, 3'b000, 2'b00, 3)); // -6/2
      add(32'h3F800000, 32'h3FC00000, 3'd1, 29, rnd_num(0, 126, 25'h0AAAAAA, 3'b100, 2'b01, 1)); // 1/1.5
      add(32'h3FC00000, 32'h3F800000, 3'd0, 29, rnd_num(0, 127, 25'h0C00000, 3'b000, 2'b00, 0)); // 1.5/1
      add(32'h00800000, 32'h40800000, 3'd0, 29, rnd_num(0, 0, 25'h0200000, 3'b000, 2'b00, 0));   // tiny, shift 2
      add(32'h00800000, 32'h4B000000, 3'd0, 29, rnd_num(0, 0, 25'h0000001, 3'b000, 2'b00, 0));   // 2^-149
      add(32'h00800000, 32'h7F000000, 3'd0, 29, rnd_num(0, 0, 25'h0000000, 3'b001, 2'b00, 0));   // shift clamped at 26
      add(32'h00800000, 32'h40400000, 3'd0, 29, rnd_num(0, 0, 25'h02AAAAA, 3'b101, 2'b01, 0));   // tiny inexact
      add(32'h00800000, 32'h40C00000, 3'd0, 29, rnd_num(0, 0, 25'h0155555, 3'b011, 2'b01, 0));   // sticky from shift
      add(32'h7F000000, 32'h00800000, 3'd0, 29, rnd_num(0, 380, 25'h0800000, 3'b000, 2'b00, 0)); // overflow passes through
      add(32'h00400000, 32'h3F000000, 3'd0, 29, rnd_num(0, 1, 25'h0800000, 3'b000, 2'b00, 0));   // subnormal dividend
      add(32'h3F800000, 32'h00000001, 3'd0, 29, rnd_num(0, 276, 25'h0800000, 3'b000, 2'b00, 0)); // subnormal divisor
      // Special operands: 1-cycle latency. flags = {snan, qnan, dbz, inf, zero}.
      add(32'h3F800000, 32'h00000000, 3'd0, 1, rnd_flag(0, 0, 5'b00100));                  // 1/0
      add(32'h00000000, 32'h00000000, 3'd0, 1, rnd_flag(0, 0, 5'b10000));                  // 0/0
      add(32'h7FC00000, 32'h3F800000, 3'd0, 1, rnd_flag(0, 0, 5'b01000));                  // qNaN/1
      add(32'hFF800000, 32'h40000000, 3'd0, 1, rnd_flag(1, 0, 5'b00010));                  // -inf/2
      add(32'h00000000, 32'h40A00000, 3'd0, 1, rnd_flag(0, 0, 5'b00001));                  // 0/5
      add(32'h3F800000, 32'h7F800000, 3'd0, 1, rnd_flag(0, 0, 5'b00001));                  // 1/inf
      add(32'h7F800000, 32'hFF800000, 3'd0, 1, rnd_flag(1, 0, 5'b10000));                  // inf/-inf
      add(32'h7F800001, 32'h3F800000, 3'd0, 1, rnd_flag(0, 0, 5'b10000));                  // sNaN/1
      add(32'h3F800000, 32'hFFC00000, 3'd0, 1, rnd_flag(1, 0, 5'b01000));                  // 1/-qNaN
      add(32'h7FC00000, 32'h00000000, 3'd0, 1, rnd_flag(0, 0, 5'b01000));                  // qNaN/0
      add(32'hFF800000, 32'h00000000, 3'd4, 1, rnd_flag(1, 4, 5'b00010));                  // -inf/0

      // Reset state.
      @(posedge clk);
      #1;
      check("reset ready/busy", 64'({bus.fp_div_ready, bus.fp_div_busy}), 64'(2'b00));
      check("reset result", 64'(bus.fp_rnd_o), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Handshake: a second start during DIV is ignored, one ready strobe.
      drive_start(32'h40C00000, 32'h40000000, 3'd0);
      n_ready     = 0;
      first_ready = 0;
      busy_ok     = 1'b1;
      for (int cyc = 1; cyc <= 29; cyc++) begin
         if (bus.fp_div_ready === 1'b1) begin
            n_ready++;
            first_ready = cyc;
         end
         if (bus.fp_div_busy !== 1'b1) busy_ok = 1'b0;
         if (cyc == 5) begin
            bus.fp_div_start = 1'b1;
            bus.fp_div_a     = 32'h3F800000;
            bus.fp_div_b     = 32'h40400000;
         end
         if (cyc == 6) bus.fp_div_start = 1'b0;
         if (cyc < 29) begin
            @(posedge clk);
            #1;
         end
      end
      check("hs ready count", 64'(n_ready), 64'(1));
      check("hs ready cycle", 64'(first_ready), 64'(29));
      check("hs busy held", 64'(busy_ok), 64'(1));
      check("hs result ignores 2nd start", 64'(bus.fp_rnd_o), 64'(exp_62));
      @(posedge clk);
      #1;
      check("hs idle after ready", 64'({bus.fp_div_ready, bus.fp_div_busy}), 64'(2'b00));
      bus.fp_div_start = 1'b1;
      bus.fp_div_a     = 32'h3F800000;
      bus.fp_div_b     = 32'h00000000;
      @(posedge clk);
      #1;
      bus.fp_div_start = 1'b0;
      check("hs back-to-back ready/busy", 64'({bus.fp_div_ready, bus.fp_div_busy}), 64'(2'b11));
      check("hs back-to-back result", 64'(bus.fp_rnd_o), 64'(rnd_flag(0, 0, 5'b00100)));
      @(posedge clk);
      #1;
      check("hs back-to-back strobe ends", 64'(bus.fp_div_ready), 64'(0));

      // Reset during cycle 10 of a divide aborts it without a ready strobe.
      drive_start(32'h40C00000, 32'h40000000, 3'd0);
      repeat (9) @(posedge clk);
      #1;
      check("rst busy before abort", 64'(bus.fp_div_busy), 64'(1));
      rst_n = 1'b0;
      #1;
      check("rst abort ready/busy", 64'({bus.fp_div_ready, bus.fp_div_busy}), 64'(2'b00));
      check("rst abort result", 64'(bus.fp_rnd_o), 64'(0));
      @(negedge clk);
      rst_n   = 1'b1;
      n_ready = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(posedge clk);
         #1;
         if (bus.fp_div_ready === 1'b1 || bus.fp_div_busy === 1'b1) n_ready++;
      end
      check("rst no ready/busy after abort", 64'(n_ready), 64'(0));
      run_vec(100, vecs[1]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
